// File: rtl/boot_pkg.sv
// Shared types and constants for the UART boot loader: the magic byte and the
// state encodings of the protocol FSM and the serial receiver.
package boot_pkg;

  localparam logic [7:0] BOOT_MAGIC = 8'hA5;

  typedef enum logic [2:0] {
    WAIT_MAGIC,
    LEN_LO,
    LEN_HI,
    DATA,
    CHECK,
    DONE,
    ERROR
  } boot_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 serial receiver: two-flop synchronizer, start-bit glitch rejection and
// bit timing. Emits one-cycle byte_valid_o or frame_err_o pulses.
module uart_rx_byte
  import boot_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int                CNT_W     = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0]  FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             r_rx_meta;
  logic             r_rx_sync;
  rx_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_byte;
  logic             r_valid;
  logic             r_ferr;

  // NOTE: every register here updates with <= in one clocked block, so all
  // reads within a cycle see the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_state   <= RX_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_byte    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_rx_meta <= rx_i;
      r_rx_sync <= r_rx_meta;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          r_cnt <= '0;
          if (!r_rx_sync) r_state <= RX_START;
        end
        RX_START: begin
          // Half a bit in: a line that is high again was only a glitch.
          if (r_cnt == HALF_LAST) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_state   <= r_rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_cnt == FULL_LAST) begin
            r_cnt     <= '0;
            r_shift   <= {r_rx_sync, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 1'b1;
            if (r_bit_idx == 3'd7) r_state <= RX_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_cnt == FULL_LAST) begin
            r_cnt   <= '0;
            r_state <= RX_IDLE;
            if (r_rx_sync) begin
              r_valid <= 1'b1;
              r_byte  <= r_shift;
            end else begin
              r_ferr <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  assign byte_o       = r_byte;
  assign byte_valid_o = r_valid;
  assign frame_err_o  = r_ferr;

endmodule

// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a length-prefixed, XOR-checked program image,
// writes it into instruction memory and holds the CPU in reset until verified.
module uart_boot_loader
  import boot_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int IMEM_DEPTH = 128,
  parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              cpu_reset_o,
  output logic              boot_done_o,
  output logic              boot_err_o
);

  localparam int          CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam logic [15:0] DEPTH_16     = 16'(IMEM_DEPTH);

  logic [7:0]  w_byte;
  logic        w_byte_valid;
  logic        w_frame_err;
  logic        w_magic;
  logic [15:0] w_len;
  logic [31:0] w_word_next;
  logic [ADDR_W:0] w_word_idx_inc;

  boot_state_t       r_state;
  logic [7:0]        r_len_lo;
  logic [ADDR_W:0]   r_len_words;
  logic [ADDR_W:0]   r_word_idx;
  logic [1:0]        r_byte_cnt;
  logic [7:0]        r_chk;
  logic [31:0]       r_word;
  logic              r_imem_we;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [31:0]       r_imem_wdata;
  logic              r_cpu_reset;
  logic              r_boot_done;
  logic              r_boot_err;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk          (clk),
    .reset        (reset),
    .rx_i         (rx_i),
    .byte_o       (w_byte),
    .byte_valid_o (w_byte_valid),
    .frame_err_o  (w_frame_err)
  );

  // NOTE: defaults assigned first so no path through this block infers a latch.
  always_comb begin
    w_magic        = w_byte_valid && (w_byte == BOOT_MAGIC);
    w_len          = {w_byte, r_len_lo};
    w_word_next    = r_word;
    w_word_next[{r_byte_cnt, 3'b000} +: 8] = w_byte;
    w_word_idx_inc = r_word_idx + {{ADDR_W{1'b0}}, 1'b1};
  end

  // Word indices never exceed IMEM_DEPTH, so an ADDR_W+1 bit index reaches
  // LEN == IMEM_DEPTH without wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= WAIT_MAGIC;
      r_len_lo     <= '0;
      r_len_words  <= '0;
      r_word_idx   <= '0;
      r_byte_cnt   <= '0;
      r_chk        <= '0;
      r_word       <= '0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_cpu_reset  <= 1'b1;
      r_boot_done  <= 1'b0;
      r_boot_err   <= 1'b0;
    end else begin
      r_imem_we <= 1'b0;
      case (r_state)
        WAIT_MAGIC, ERROR: begin
          if (w_magic) begin
            r_state    <= LEN_LO;
            r_word_idx <= '0;
            r_byte_cnt <= '0;
            r_chk      <= '0;
            r_boot_err <= 1'b0;
          end
        end
        LEN_LO: begin
          if (w_frame_err) begin
            r_state    <= ERROR;
            r_boot_err <= 1'b1;
          end else if (w_byte_valid) begin
            r_len_lo <= w_byte;
            r_state  <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (w_frame_err || (w_byte_valid && w_len > DEPTH_16)) begin
            r_state    <= ERROR;
            r_boot_err <= 1'b1;
          end else if (w_byte_valid) begin
            r_len_words <= w_len[ADDR_W:0];
            r_state     <= (w_len == 16'd0) ? CHECK : DATA;
          end
        end
        DATA: begin
          if (w_frame_err) begin
            r_state    <= ERROR;
            r_boot_err <= 1'b1;
          end else if (w_byte_valid) begin
            r_word     <= w_word_next;
            r_chk      <= r_chk ^ w_byte;
            r_byte_cnt <= r_byte_cnt + 1'b1;
            if (r_byte_cnt == 2'd3) begin
              r_imem_we    <= 1'b1;
              r_imem_addr  <= r_word_idx[ADDR_W-1:0];
              r_imem_wdata <= w_word_next;
              r_word_idx   <= w_word_idx_inc;
              if (w_word_idx_inc == r_len_words) r_state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (w_frame_err || (w_byte_valid && w_byte != r_chk)) begin
            r_state    <= ERROR;
            r_boot_err <= 1'b1;
          end else if (w_byte_valid) begin
            r_state     <= DONE;
            r_cpu_reset <= 1'b0;
            r_boot_done <= 1'b1;
          end
        end
        DONE: ;
        default: r_state <= WAIT_MAGIC;
      endcase
    end
  end

  assign imem_we_o    = r_imem_we;
  assign imem_addr_o  = r_imem_addr;
  assign imem_wdata_o = r_imem_wdata;
  assign cpu_reset_o  = r_cpu_reset;
  assign boot_done_o  = r_boot_done;
  assign boot_err_o   = r_boot_err;

endmodule
